// File: rtl/tetris_pkg.sv
// Shared definitions for the piece-movement scheduling logic.
//   move_cmd_t   : command encoding driven on move_cmd
//   KEY_*        : USB HID keycodes that map to commands
//   DAS_DEFAULT  : frames a key is held before auto-repeat begins
//   ARR_DEFAULT  : frames between auto-repeats
//   map_key      : keycode -> command (CMD_NONE for unmapped keys)
//   grav_period  : gravity period in frames for a level, max(30 - 2*level, 2)
package tetris_pkg;

  typedef enum logic [2:0] {
    CMD_NONE   = 3'd0,
    CMD_LEFT   = 3'd1,
    CMD_RIGHT  = 3'd2,
    CMD_DOWN   = 3'd3,
    CMD_ROTATE = 3'd4,
    CMD_DROP   = 3'd5
  } move_cmd_t;

  localparam logic [7:0] KEY_LEFT   = 8'h04;
  localparam logic [7:0] KEY_RIGHT  = 8'h07;
  localparam logic [7:0] KEY_DOWN   = 8'h16;
  localparam logic [7:0] KEY_ROTATE = 8'h1A;
  localparam logic [7:0] KEY_DROP   = 8'h2C;

  localparam int DAS_DEFAULT = 10;
  localparam int ARR_DEFAULT = 3;

  function automatic move_cmd_t map_key(input logic [7:0] kc);
    case (kc)
      KEY_LEFT:   return CMD_LEFT;
      KEY_RIGHT:  return CMD_RIGHT;
      KEY_DOWN:   return CMD_DOWN;
      KEY_ROTATE: return CMD_ROTATE;
      KEY_DROP:   return CMD_DROP;
      default:    return CMD_NONE;
    endcase
  endfunction

  // Levels 14 and 15 would give 2 and 0; both clamp to the 2-frame floor.
  function automatic logic [4:0] grav_period(input logic [3:0] lvl);
    if (lvl >= 4'd14) return 5'd2;
    return 5'd30 - {lvl, 1'b0};
  endfunction

endpackage

// File: rtl/key_repeat.sv
// Key press detection with delayed auto-repeat.
//   frame_clk : clock, all updates on posedge
//   Reset     : synchronous, active-high
//   keycode   : current HID keycode (0x00 = none)
//   pause     : freezes sampling and counters, suppresses events
//   key_event : a key event should be registered this cycle
//   key_cmd   : command mapped from the current keycode
// A change of keycode is a new press. LEFT/RIGHT/DOWN held unchanged fire
// again DAS_FRAMES edges after the press edge, then every ARR_FRAMES edges.
module key_repeat
  import tetris_pkg::*;
#(
  parameter int DAS_FRAMES = DAS_DEFAULT,
  parameter int ARR_FRAMES = ARR_DEFAULT
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       pause,
  output logic       key_event,
  output move_cmd_t  key_cmd
);

  localparam int HOLD_W = ($clog2(DAS_FRAMES + 1) > 6) ? $clog2(DAS_FRAMES + 1) : 6;
  localparam int ARR_W  = ($clog2(ARR_FRAMES + 1) > 6) ? $clog2(ARR_FRAMES + 1) : 6;
  localparam logic [HOLD_W-1:0] DAS_LAST   = HOLD_W'(DAS_FRAMES - 1);
  localparam logic [HOLD_W-1:0] DAS_SAT    = HOLD_W'(DAS_FRAMES);
  localparam logic [ARR_W-1:0]  ARR_RELOAD = ARR_W'(ARR_FRAMES - 1);

  logic [7:0]        prev_key;
  logic [HOLD_W-1:0] hold_cnt;
  logic [ARR_W-1:0]  arr_cnt;
  logic              new_press;
  logic              repeatable;
  logic              das_hit;
  logic              arr_hit;

  assign key_cmd    = map_key(keycode);
  assign new_press  = (keycode != prev_key);
  assign repeatable = key_cmd inside {CMD_LEFT, CMD_RIGHT, CMD_DOWN};

  // hold_cnt parks at DAS_FRAMES once the initial delay has elapsed; from
  // then on arr_cnt is a down-counter that fires at zero and reloads.
  assign das_hit = repeatable && !new_press && (hold_cnt == DAS_LAST);
  assign arr_hit = repeatable && !new_press && (hold_cnt == DAS_SAT) && (arr_cnt == '0);

  assign key_event = !pause && (new_press ? (key_cmd != CMD_NONE) : (das_hit || arr_hit));

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      prev_key <= 8'h00;
      hold_cnt <= '0;
      arr_cnt  <= '0;
    end else if (!pause) begin
      prev_key <= keycode;
      if (new_press) begin
        hold_cnt <= '0;
        arr_cnt  <= '0;
      end else if (repeatable) begin
        if (hold_cnt != DAS_SAT) hold_cnt <= hold_cnt + 1'b1;
        if (das_hit || arr_hit) arr_cnt <= ARR_RELOAD;
        else if (arr_cnt != '0) arr_cnt <= arr_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/move_scheduler.sv
// Arbitrates key and gravity events into a single move command handshake.
//   frame_clk  : clock, all updates on posedge
//   Reset      : synchronous, active-high
//   keycode    : current HID keycode (0x00 = none)
//   level      : gravity level 0..15
//   pause      : freezes gravity, key sampling and new selections
//   move_ack   : datapath has applied/rejected the current command
//   move_ok    : with move_ack, 1 = move performed, 0 = blocked
//   move_req   : command valid (high exactly while in ISSUE)
//   move_cmd   : command encoding (move_cmd_t)
//   lock_pulse : one-cycle request to lock the piece
//
// state | meaning
// IDLE  | no command outstanding; selects the next pending event
// ISSUE | move_cmd presented with move_req, waiting for move_ack
module move_scheduler
  import tetris_pkg::*;
#(
  parameter int DAS_FRAMES = DAS_DEFAULT,
  parameter int ARR_FRAMES = ARR_DEFAULT
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [3:0] level,
  input  logic       pause,
  input  logic       move_ack,
  input  logic       move_ok,
  output logic       move_req,
  output logic [2:0] move_cmd,
  output logic       lock_pulse
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  logic [0:0] state;
  move_cmd_t  cur_cmd;

  logic       key_event;
  move_cmd_t  key_cmd;
  logic       key_pend;
  move_cmd_t  key_pend_cmd;
  logic       grav_pend;
  logic [4:0] grav_cnt;

  logic       grav_hit;
  logic       key_any;
  logic       grav_any;
  logic       select;
  move_cmd_t  key_eff_cmd;
  move_cmd_t  sel_cmd;
  logic       serve_down;

  key_repeat #(
    .DAS_FRAMES (DAS_FRAMES),
    .ARR_FRAMES (ARR_FRAMES)
  ) u_key_repeat (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .pause     (pause),
    .key_event (key_event),
    .key_cmd   (key_cmd)
  );

  // >= rather than == so a level change never lets the counter run past
  // the new period and wrap.
  assign grav_hit = !pause && (grav_cnt >= (grav_period(level) - 5'd1));

  // Events arriving this cycle are visible to selection directly, so an
  // idle scheduler issues on the same edge the event occurs.
  assign key_any     = key_event || key_pend;
  assign key_eff_cmd = key_event ? key_cmd : key_pend_cmd;
  assign grav_any    = grav_hit || grav_pend;

  // Only one key event is ever held (newest overwrites), so the
  // DROP > ROTATE > LEFT/RIGHT > key DOWN order collapses to "key first",
  // with gravity DOWN last.
  assign select     = (state == IDLE) && !pause && (key_any || grav_any);
  assign sel_cmd    = key_any ? key_eff_cmd : CMD_DOWN;
  assign serve_down = select && (sel_cmd == CMD_DOWN);

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state        <= IDLE;
      cur_cmd      <= CMD_NONE;
      lock_pulse   <= 1'b0;
      key_pend     <= 1'b0;
      key_pend_cmd <= CMD_NONE;
      grav_pend    <= 1'b0;
      grav_cnt     <= 5'd0;
    end else begin
      lock_pulse <= 1'b0;

      if (select && key_any) begin
        key_pend <= 1'b0;
      end else if (key_event) begin
        key_pend     <= 1'b1;
        key_pend_cmd <= key_cmd;
      end

      // Any DOWN, key or gravity, restarts the gravity interval.
      if (serve_down) begin
        grav_cnt  <= 5'd0;
        grav_pend <= 1'b0;
      end else if (grav_hit) begin
        grav_cnt  <= 5'd0;
        grav_pend <= 1'b1;
      end else if (!pause) begin
        grav_cnt <= grav_cnt + 5'd1;
      end

      case (state)
        IDLE: begin
          if (select) begin
            state   <= ISSUE;
            cur_cmd <= sel_cmd;
          end
        end
        ISSUE: begin
          if (move_ack) begin
            state      <= IDLE;
            cur_cmd    <= CMD_NONE;
            lock_pulse <= (cur_cmd == CMD_DROP) || ((cur_cmd == CMD_DOWN) && !move_ok);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign move_req = (state == ISSUE);
  assign move_cmd = cur_cmd;

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler. Edge numbers in comments count posedges
// after Reset is released (edge 1 is the first non-reset edge).
module tb_move_scheduler;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode;
  logic [3:0] level;
  logic       pause;
  logic       move_ack;
  logic       move_ok;
  logic       move_req;
  logic [2:0] move_cmd;
  logic       lock_pulse;

  int total = 0;
  int bad   = 0;
  int rises [16];
  int rcmd  [16];
  int nr;
  int edge_at;

  move_scheduler #(.DAS_FRAMES(10), .ARR_FRAMES(3)) dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .keycode    (keycode),
    .level      (level),
    .pause      (pause),
    .move_ack   (move_ack),
    .move_ok    (move_ok),
    .move_req   (move_req),
    .move_cmd   (move_cmd),
    .lock_pulse (lock_pulse)
  );

  always #5 frame_clk = ~frame_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic do_reset();
    Reset    = 1'b1;
    keycode  = 8'h00;
    pause    = 1'b0;
    move_ack = 1'b0;
    move_ok  = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  // Runs n edges acking every request in its first ISSUE cycle and logs
  // the edge number and command of each request.
  task automatic run_auto(input int n);
    nr = 0;
    for (int i = 0; i < 16; i++) begin
      rises[i] = -1;
      rcmd[i]  = -1;
    end
    for (int k = 1; k <= n; k++) begin
      tick();
      if (move_req) begin
        if (nr < 16) begin
          rises[nr] = k;
          rcmd[nr]  = int'(move_cmd);
        end
        nr++;
      end
      move_ack = move_req;
    end
    move_ack = 1'b0;
  endtask

  initial begin
    level = 4'd0;
    do_reset();
    chk("reset_req", move_req, 0);
    chk("reset_cmd", move_cmd, 0);
    chk("reset_lock", lock_pulse, 0);

    // Level 0: period 30, DOWN requests at edges 30, 60, 90.
    run_auto(95);
    chk("grav0_count", nr, 3);
    chk("grav0_r0", rises[0], 30);
    chk("grav0_r1", rises[1], 60);
    chk("grav0_r2", rises[2], 90);
    chk("grav0_cmd0", rcmd[0], 3);
    chk("grav0_cmd2", rcmd[2], 3);

    // Level 13: period 4.
    do_reset();
    level = 4'd13;
    run_auto(10);
    chk("grav13_count", nr, 2);
    chk("grav13_r0", rises[0], 4);
    chk("grav13_r1", rises[1], 8);

    // Level 15: period clamps to 2.
    do_reset();
    level = 4'd15;
    run_auto(8);
    chk("grav15_count", nr, 4);
    chk("grav15_r0", rises[0], 2);
    chk("grav15_r1", rises[1], 4);

    // LEFT held 20 edges: press at 1, DAS at 11, repeats at 14, 17, 20.
    do_reset();
    level   = 4'd0;
    keycode = 8'h04;
    run_auto(20);
    chk("das_count", nr, 5);
    chk("das_r0", rises[0], 1);
    chk("das_r1", rises[1], 11);
    chk("das_r2", rises[2], 14);
    chk("das_r3", rises[3], 17);
    chk("das_r4", rises[4], 20);
    chk("das_cmd1", rcmd[1], 1);
    chk("das_cmd4", rcmd[4], 1);

    // DROP pressed on the edge gravity fires (edge 30).
    do_reset();
    repeat (29) tick();
    keycode = 8'h2C;
    tick();
    chk("drop_req", move_req, 1);
    chk("drop_cmd", move_cmd, 5);
    move_ack = 1'b1;
    tick();
    chk("drop_ack_req", move_req, 0);
    chk("drop_lock", lock_pulse, 1);
    move_ack = 1'b0;
    tick();
    chk("after_drop_cmd", move_cmd, 3);
    chk("after_drop_req", move_req, 1);
    chk("after_drop_lock", lock_pulse, 0);
    // Gravity DOWN blocked: lock for exactly one cycle.
    move_ack = 1'b1;
    move_ok  = 1'b0;
    tick();
    chk("blocked_req", move_req, 0);
    chk("blocked_lock", lock_pulse, 1);
    move_ack = 1'b0;
    move_ok  = 1'b1;
    tick();
    chk("blocked_lock_off", lock_pulse, 0);
    // DOWN served at edge 32 restarts gravity: next DOWN at edge 62.
    edge_at = -1;
    for (int k = 35; k <= 80; k++) begin
      tick();
      if (move_req && edge_at < 0) edge_at = k;
    end
    chk("grav_restart_edge", edge_at, 62);

    // Ack withheld for 5 cycles; ROTATE pressed during the wait.
    do_reset();
    keycode = 8'h04;
    tick();
    chk("wait_e1", {move_req, move_cmd}, 4'b1001);
    keycode = 8'h1A;
    for (int k = 2; k <= 5; k++) begin
      tick();
      chk("wait_stable", {move_req, move_cmd}, 4'b1001);
    end
    move_ack = 1'b1;
    tick();
    chk("wait_ack_req", move_req, 0);
    chk("wait_ack_lock", lock_pulse, 0);
    move_ack = 1'b0;
    tick();
    chk("rot_req", move_req, 1);
    chk("rot_cmd", move_cmd, 4);

    // Reset in ISSUE, then 40 paused cycles with a key and fast gravity.
    Reset = 1'b1;
    pause = 1'b1;
    tick();
    chk("rst_issue_req", move_req, 0);
    chk("rst_issue_cmd", move_cmd, 0);
    Reset   = 1'b0;
    keycode = 8'h04;
    level   = 4'd15;
    for (int k = 0; k < 40; k++) begin
      tick();
      chk("paused_outputs", {move_req, move_cmd, lock_pulse}, 5'b00000);
    end
    pause = 1'b0;
    tick();
    chk("unpause_req", move_req, 1);
    chk("unpause_cmd", move_cmd, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
